imem_loadable: RTL and testbench
================================

# imem_loadable

Parametrised synchronous instruction memory for the pipelined MIPS core's IF stage: registered single-cycle fetch with stall hold, flush-to-NOP and out-of-range detection. Also has a streaming load port that fills the array from word 0 upward after reset, or when a reload is requested. Fetch is disabled while loading. The block replaces the fixed 512×32, PC-indexed fetch memory.

## Interface
Parameters:
- DATA_W, 32, instruction width
- ADDR_W, 32, PC width
- DEPTH, 512, number of instruction words (≥2)
- BYTE_ADDR, 1, 1: word index = pc >> 2 and pc[1:0] must be 0; 0: word index = pc
- NOP, 32'h0000_0000, value driven on inst when no valid instruction is presented
- CNT_W, $clog2(DEPTH+1), width of ld_count

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc  in  ADDR_W  fetch address
- fetch_en  in  1  1: sample pc this cycle; 0: stall, hold outputs
- flush  in  1  kill the output instruction
- inst  out  DATA_W  fetched instruction (registered)
- inst_valid  out  1  inst holds a valid in-range instruction
- addr_err  out  1  last fetch was out of range or misaligned (registered alongside inst)
- parity_err  out  1  last fetch failed its parity check (registered alongside inst)
- reload  in  1  RUN→LOAD request
- ld_valid  in  1  load word offered
- ld_ready  out  1  block accepts load words (state==LOAD and !rst)
- ld_data  in  DATA_W  load word
- ld_last  in  1  marks the final load word
- ld_count  out  CNT_W  words accepted in the current load
- loaded  out  1  state==RUN

## Operation
- States: LOAD and RUN. Reset state is LOAD.
- In LOAD:
  - A word is accepted on any cycle with ld_valid & ld_ready. It is written to mem[ld_count], then ld_count increments.
  - LOAD→RUN when an accepted word has ld_last=1, or when ld_count reaches DEPTH (array full).
  - Fetch is ignored in LOAD. inst=NOP, inst_valid=0, addr_err=0, parity_err=0.
- In RUN:
  - ld_ready=0, and ld_valid is ignored.
  - reload=1 causes RUN→LOAD on the next edge and clears ld_count to 0. Outputs go to their LOAD values on that same edge.
  - Memory contents are retained; words beyond the new load's count keep their old contents.
- Fetch in RUN, with this per-edge priority:
  1. flush: inst←NOP, inst_valid←0, addr_err←0, parity_err←0.
  2. !fetch_en: all fetch outputs hold.
  3. Otherwise compute idx from pc.
     - Out of range (idx ≥ DEPTH, or BYTE_ADDR=1 and pc[1:0]≠0): inst←NOP, inst_valid←0, addr_err←1.
     - Else: inst←mem[idx], inst_valid←1, addr_err←0.
- Fetch range is not limited by ld_count: unloaded words read whatever the array holds.
- Memory array has no reset. Contents are undefined until written.
- Reset values: inst=NOP, inst_valid=0, addr_err=0, parity_err=0, ld_count=0, loaded=0. ld_ready=0 while rst=1 and 1 on the first cycle after rst falls.
- rst during LOAD or RUN aborts immediately. Partially loaded data stays in the array and the next load overwrites it from word 0.

## Timing
- Fetch latency is 1 cycle: pc sampled at edge N, inst/inst_valid/addr_err valid after edge N.
- Throughput: one fetch per cycle, back-to-back.
- A load word is written at the accepting edge. Throughput is one word per cycle; ld_ready stays high for the whole LOAD state.
- The edge accepting the last (or DEPTH-th) word also sets loaded=1 and drops ld_ready. The first fetch may be sampled on the following edge.
- flush and fetch_en=1 in the same cycle: flush wins and pc is discarded.
- reload and flush in the same cycle: reload wins.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed from ld_data at load.
  - An in-range fetch recomputes parity and sets parity_err←1 on mismatch. inst_valid stays 1, so the core decides how to react.
- IMEM_PARITY_EN undefined:
  - No parity storage.
  - parity_err port is still present and constant 0.

## Test plan
- Reset, then load 4 words (0x20080001, 0x20090002, 0x01095020, 0xAC0A0000) with ld_last on the 4th → ld_count=4, loaded=1 on that edge, ld_ready=0.
- BYTE_ADDR=1, fetch pc=0,4,8,12 back-to-back → inst equals the 4 words in order, each 1 cycle after its pc, inst_valid=1.
- fetch_en=0 for 3 cycles mid-stream → inst held. flush=1 with fetch_en=1 → next inst=NOP, inst_valid=0.
- pc=0x802 (misaligned) and pc=DEPTH*4 → inst=NOP, inst_valid=0, addr_err=1. Next aligned fetch clears addr_err.
- Stream DEPTH words with no ld_last → auto RUN at ld_count=DEPTH. An extra ld_valid is not accepted. reload then returns to LOAD with ld_count=0. rst asserted mid-load → all outputs at reset values next cycle.
- With IMEM_PARITY_EN, force a stored bit flip on word 2, fetch pc=8 → parity_err=1, inst_valid=1. Without the macro, parity_err is always 0.

Source files
------------

// File: rtl/imem_loadable_if.sv
// Fetch and load-stream bundle for imem_loadable.
// master: core/loader side, slave: memory side.
interface imem_loadable_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 10
);
  logic [ADDR_W-1:0] pc;
  logic              fetch_en;
  logic              flush;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              addr_err;
  logic              parity_err;
  logic              reload;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic [CNT_W-1:0]  ld_count;
  logic              loaded;

  modport master (
    output pc, fetch_en, flush,
    output reload, ld_valid, ld_data, ld_last,
    input  inst, inst_valid, addr_err, parity_err,
    input  ld_ready, ld_count, loaded
  );

  modport slave (
    input  pc, fetch_en, flush,
    input  reload, ld_valid, ld_data, ld_last,
    output inst, inst_valid, addr_err, parity_err,
    output ld_ready, ld_count, loaded
  );
endinterface

// File: rtl/imem_loadable.sv
// Loadable IF-stage instruction memory: registered fetch, stream loader.
// Optional per-word even parity enabled by defining IMEM_PARITY_EN.
module imem_loadable #(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 32,
  parameter int              DEPTH     = 512,
  parameter int              BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP     = '0,
  parameter int              CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  imem_loadable_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] inst_q;
  logic              valid_q;
  logic              aerr_q;
  logic              perr_q;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic              par_mem [DEPTH];
`endif

  logic              ld_ready;
  logic              accept;
  logic              last_hit;
  logic [IDX_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] word;
  logic              misal;
  logic              oor;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic              par_bad;

  // Load handshake: ready for the whole LOAD state, never during reset
  always_comb begin
    ld_ready = (state == S_LOAD) && !rst;
    accept   = bus.ld_valid && ld_ready;
    last_hit = bus.ld_last ||
               (cnt == CNT_W'(DEPTH - 1));
    wr_idx   = cnt[IDX_W-1:0];
  end

  // Fetch address decode and range/alignment check
  always_comb begin
    if (BYTE_ADDR != 0) begin
      word  = bus.pc >> 2;
      misal = (bus.pc[1:0] != 2'b00);
    end else begin
      word  = bus.pc;
      misal = 1'b0;
    end
    oor     = misal || (word >= ADDR_W'(DEPTH));
    rd_idx  = word[IDX_W-1:0];
    rd_data = mem[rd_idx];
`ifdef IMEM_PARITY_EN
    par_bad = (^rd_data) != par_mem[rd_idx];
`else
    par_bad = 1'b0;
`endif
  end

  // Array write port; the array itself is never reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx] <= bus.ld_data;
`ifdef IMEM_PARITY_EN
      par_mem[wr_idx] <= ^bus.ld_data;
`endif
    end
  end

  // Control FSM, load counter and registered fetch outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_LOAD;
      cnt     <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          inst_q  <= NOP;
          valid_q <= 1'b0;
          aerr_q  <= 1'b0;
          perr_q  <= 1'b0;
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (last_hit) begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.reload) begin
            state   <= S_LOAD;
            cnt     <= '0;
            inst_q  <= NOP;
            valid_q <= 1'b0;
            aerr_q  <= 1'b0;
            perr_q  <= 1'b0;
          end else if (bus.flush) begin
            inst_q  <= NOP;
            valid_q <= 1'b0;
            aerr_q  <= 1'b0;
            perr_q  <= 1'b0;
          end else if (bus.fetch_en) begin
            if (oor) begin
              inst_q  <= NOP;
              valid_q <= 1'b0;
              aerr_q  <= 1'b1;
              perr_q  <= 1'b0;
            end else begin
              inst_q  <= rd_data;
              valid_q <= 1'b1;
              aerr_q  <= 1'b0;
              perr_q  <= par_bad;
            end
          end
        end
        default: begin
          state <= S_LOAD;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.ld_count   = cnt;
  assign bus.loaded     = (state == S_RUN);
  assign bus.inst       = inst_q;
  assign bus.inst_valid = valid_q;
  assign bus.addr_err   = aerr_q;
`ifdef IMEM_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable (DEPTH=16, byte addressing).
// Parity flip check runs only when IMEM_PARITY_EN is defined.
module tb_imem_loadable;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  logic rst;

  int pass_cnt = 0;
  int total    = 0;

  logic [31:0] w [4];

  imem_loadable_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) bus ();

  imem_loadable #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .BYTE_ADDR(1), .NOP(32'h0000_0000), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic load_word(input logic [31:0] d,
                           input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.pc = a;
    bus.fetch_en = 1'b1;
    tick();
  endtask

  initial begin
    w[0] = 32'h2008_0001;
    w[1] = 32'h2009_0002;
    w[2] = 32'h0109_5020;
    w[3] = 32'hAC0A_0000;

    rst          = 1'b1;
    bus.pc       = '0;
    bus.fetch_en = 1'b0;
    bus.flush    = 1'b0;
    bus.reload   = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    tick();
    tick();

    chk("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
    chk("rst_inst", 64'(bus.inst), 64'h0);
    chk("rst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_aerr", 64'(bus.addr_err), 64'd0);
    chk("rst_perr", 64'(bus.parity_err), 64'd0);
    chk("rst_count", 64'(bus.ld_count), 64'd0);
    chk("rst_loaded", 64'(bus.loaded), 64'd0);

    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(bus.ld_ready), 64'd1);

    load_word(w[0], 1'b0);
    chk("count_1", 64'(bus.ld_count), 64'd1);
    chk("loaded_mid", 64'(bus.loaded), 64'd0);
    load_word(w[1], 1'b0);
    load_word(w[2], 1'b0);
    load_word(w[3], 1'b1);
    chk("count_4", 64'(bus.ld_count), 64'd4);
    chk("loaded_4", 64'(bus.loaded), 64'd1);
    chk("ready_off", 64'(bus.ld_ready), 64'd0);
    chk("inst_nop_load", 64'(bus.inst_valid), 64'd0);

    for (int i = 0; i < 4; i++) begin
      fetch(32'(4 * i));
      chk("fetch_inst", 64'(bus.inst), 64'(w[i]));
      chk("fetch_valid", 64'(bus.inst_valid), 64'd1);
    end

    bus.fetch_en = 1'b0;
    bus.pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", 64'(bus.inst), 64'(w[3]));
      chk("stall_valid", 64'(bus.inst_valid), 64'd1);
    end

    bus.flush = 1'b1;
    fetch(32'h4);
    bus.flush = 1'b0;
    chk("flush_inst", 64'(bus.inst), 64'h0);
    chk("flush_valid", 64'(bus.inst_valid), 64'd0);

    fetch(32'h802);
    chk("misal_inst", 64'(bus.inst), 64'h0);
    chk("misal_valid", 64'(bus.inst_valid), 64'd0);
    chk("misal_aerr", 64'(bus.addr_err), 64'd1);
    fetch(32'(DEPTH * 4));
    chk("oor_aerr", 64'(bus.addr_err), 64'd1);
    chk("oor_valid", 64'(bus.inst_valid), 64'd0);
    fetch(32'h4);
    chk("aerr_clear", 64'(bus.addr_err), 64'd0);
    chk("after_err_inst", 64'(bus.inst), 64'(w[1]));

`ifdef IMEM_PARITY_EN
    dut.mem[2][0] = ~dut.mem[2][0];
    fetch(32'h8);
    chk("par_err", 64'(bus.parity_err), 64'd1);
    chk("par_valid", 64'(bus.inst_valid), 64'd1);
`else
    fetch(32'h8);
    chk("par_off", 64'(bus.parity_err), 64'd0);
    chk("par_off_inst", 64'(bus.inst), 64'(w[2]));
`endif

    bus.reload = 1'b1;
    bus.flush  = 1'b1;
    fetch(32'h0);
    bus.reload = 1'b0;
    bus.flush  = 1'b0;
    chk("reload_loaded", 64'(bus.loaded), 64'd0);
    chk("reload_count", 64'(bus.ld_count), 64'd0);
    chk("reload_ready", 64'(bus.ld_ready), 64'd1);
    chk("reload_valid", 64'(bus.inst_valid), 64'd0);

    load_word(32'hAAAA_0000, 1'b0);
    load_word(32'hBBBB_0001, 1'b1);
    chk("partial_count", 64'(bus.ld_count), 64'd2);
    fetch(32'h0);
    chk("partial_new", 64'(bus.inst), 64'hAAAA_0000);
    fetch(32'hC);
    chk("partial_old", 64'(bus.inst), 64'(w[3]));

    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("stream_ready", 64'(bus.ld_ready), 64'd1);
      load_word(32'h0000_1000 + 32'(i), 1'b0);
    end
    chk("full_count", 64'(bus.ld_count), 64'(DEPTH));
    chk("full_loaded", 64'(bus.loaded), 64'd1);
    chk("full_ready", 64'(bus.ld_ready), 64'd0);

    bus.pc = 32'h0;
    bus.fetch_en = 1'b1;
    load_word(32'h0000_DEAD, 1'b1);
    chk("extra_count", 64'(bus.ld_count), 64'(DEPTH));
    chk("extra_inst", 64'(bus.inst), 64'h1000);
    fetch(32'(4 * (DEPTH - 1)));
    chk("last_word", 64'(bus.inst), 64'h100F);

    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_word(32'h9000_0000 + 32'(i), 1'b0);
    end
    chk("abort_pre_count", 64'(bus.ld_count), 64'd3);
    rst = 1'b1;
    tick();
    chk("abort_count", 64'(bus.ld_count), 64'd0);
    chk("abort_loaded", 64'(bus.loaded), 64'd0);
    chk("abort_ready", 64'(bus.ld_ready), 64'd0);
    chk("abort_inst", 64'(bus.inst), 64'h0);
    chk("abort_valid", 64'(bus.inst_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready_up", 64'(bus.ld_ready), 64'd1);

    load_word(32'h1234_5678, 1'b1);
    chk("reload_loaded2", 64'(bus.loaded), 64'd1);
    fetch(32'h0);
    chk("relo_w0", 64'(bus.inst), 64'h1234_5678);
    fetch(32'h4);
    chk("relo_w1", 64'(bus.inst), 64'h9000_0001);
    fetch(32'h14);
    chk("relo_w5", 64'(bus.inst), 64'h1005);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
